mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle RV32M execute-stage unit. Consumes the two register-file read operands (after forwarding) and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Raises BUSY so the hazard unit stalls the pipeline. Pulses DONE with RESULT for the EX/MEM pipeline register.
- All state updates on posedge CLK.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.

Ports:
- CLK  input  1  clock; all state updates on posedge
- RESET  input  1  synchronous, active-high reset
- START  input  1  request; sampled only when the unit is idle
- FUNCT3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- DATA1  input  32  rs1 operand (multiplicand / dividend)
- DATA2  input  32  rs2 operand (multiplier / divisor)
- RESULT  output  32  registered result; holds its value until the next completion
- BUSY  output  1  high from the accepting edge until the completion edge
- DONE  output  1  one-cycle pulse; RESULT valid while DONE is high

Behaviour:
- Reset (RESET high at posedge):
  - state=IDLE, RESULT=0, BUSY=0, DONE=0, internal operand/iteration registers cleared.
  - Aborts any op in progress. No DONE is produced for an aborted op.
- States and transitions:
  - IDLE: on START, latch DATA1, DATA2 and FUNCT3 at edge N and set BUSY=1.
    - FUNCT3[2]=0 -> MUL.
    - FUNCT3[2]=1 with divisor 0 or signed overflow -> SPECIAL.
    - Otherwise -> DIV.
  - MUL: full 64-bit product of the operands.
    - MUL, MULHU: unsigned × unsigned.
    - MULH: signed × signed.
    - MULHSU: signed rs1 × unsigned rs2.
    - MUL takes low word; MULH/MULHSU/MULHU take high word.
    - At edge N+1: RESULT written, BUSY=0, DONE=1 for one cycle, state -> IDLE.
  - SPECIAL: at edge N+1, RESULT written as follows, then DONE pulse and state -> IDLE.
    - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
    - Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
  - DIV: radix-2 restoring division on magnitudes.
    - Signed ops take absolute values; unsigned ops use raw values.
    - 33-bit partial remainder, one quotient bit per cycle, 32 iterations at edges N+1..N+32.
    - At edge N+33: sign fix-up, RESULT written, DONE pulse, state -> IDLE.
    - Sign fix-up: quotient negated if the operand signs differ (signed op only). Remainder takes the dividend's sign.
- Latency: START to DONE is 1 cycle for MUL/SPECIAL and 33 cycles for DIV.
- DONE is high in the cycle after the completion edge. State is IDLE in that same cycle, so a START there is accepted (back-to-back ops allowed).
- START while BUSY=1: ignored. Operands and FUNCT3 are not re-latched.
- Operands are latched at acceptance. Input changes after edge N have no effect.
- RESET and START asserted together: RESET wins; op not accepted.
- x0 semantics belong to the writeback/register file. The unit always produces a RESULT.

Test Plan:
- Reset, then MUL DATA1=7, DATA2=0xFFFFFFFD -> DONE 1 cycle after START, RESULT=0xFFFFFFEB.
- High-word variants, 1-cycle latency each:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> DONE exactly 33 cycles after START, RESULT=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- Special cases, each 1-cycle latency:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start DIVU 100/7, pulse START with MUL 3×3 at cycle 5 -> ignored; DIVU completes with 14. Then MUL 3×3 issued in the DONE cycle -> accepted, RESULT=9 one cycle later.
- Start DIV, assert RESET at cycle 10 -> after that edge BUSY=0, RESULT=0, no DONE within 40 cycles. A subsequent DIVU 9/3 -> 3 after 33 cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
// RV32M execute-stage multiply/divide unit: single-cycle multiply, 32-step restoring divide.
// BUSY stalls the pipeline while an op is in flight; DONE pulses with the registered RESULT.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SPECIAL,
    S_DIV,
    S_FIX
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [XLEN-1:0] opa_p0;
  logic [XLEN-1:0] opb_p0;
  logic [1:0]      fn_p0;
  logic [XLEN:0]   rem_p1;
  logic [XLEN-1:0] quo_p1;
  logic [XLEN-1:0] dvs_p1;
  logic [4:0]      cnt_p1;
  logic            neg_q_p1;
  logic            neg_r_p1;

  logic sgn_in;
  logic special_in;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // fn: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
  function automatic logic [XLEN-1:0] mul_word(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [1:0]      fn);
    logic signed [2*XLEN-1:0] a_w;
    logic signed [2*XLEN-1:0] b_w;
    logic signed [2*XLEN-1:0] prod;
    logic a_s;
    logic b_s;
    a_s  = (fn == 2'b01) || (fn == 2'b10);
    b_s  = (fn == 2'b01);
    a_w  = {{XLEN{a_s & a[XLEN-1]}}, a};
    b_w  = {{XLEN{b_s & b[XLEN-1]}}, b};
    prod = a_w * b_w;
    return (fn == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] special_word(input logic [XLEN-1:0] dividend,
                                                   input logic            is_rem,
                                                   input logic            dvs_zero);
    if (dvs_zero)
      return is_rem ? dividend : '1;
    return is_rem ? '0 : INT_MIN;
  endfunction

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  function automatic logic [2*XLEN:0] div_step(input logic [XLEN:0]   rem,
                                               input logic [XLEN-1:0] quo,
                                               input logic [XLEN-1:0] dvs);
    logic [XLEN:0] cand;
    logic          ge;
    cand = {rem[XLEN-1:0], quo[XLEN-1]};
    ge   = rem[XLEN] || (cand >= {1'b0, dvs});
    return {(ge ? cand - {1'b0, dvs} : cand), quo[XLEN-2:0], ge};
  endfunction

  always_comb begin
    sgn_in     = ~FUNCT3[0];
    special_in = (DATA2 == '0) || (sgn_in && (DATA1 == INT_MIN) && (DATA2 == '1));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      RESULT   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      opa_p0   <= '0;
      opb_p0   <= '0;
      fn_p0    <= '0;
      rem_p1   <= '0;
      quo_p1   <= '0;
      dvs_p1   <= '0;
      cnt_p1   <= '0;
      neg_q_p1 <= 1'b0;
      neg_r_p1 <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        // stage p0: accept and latch operands
        S_IDLE: begin
          if (START) begin
            opa_p0 <= DATA1;
            opb_p0 <= DATA2;
            fn_p0  <= FUNCT3[1:0];
            BUSY   <= 1'b1;
            if (!FUNCT3[2]) begin
              state <= S_MUL;
            end else if (special_in) begin
              state <= S_SPECIAL;
            end else begin
              state    <= S_DIV;
              rem_p1   <= '0;
              quo_p1   <= mag(DATA1, sgn_in);
              dvs_p1   <= mag(DATA2, sgn_in);
              cnt_p1   <= '0;
              neg_q_p1 <= sgn_in & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
              neg_r_p1 <= sgn_in & DATA1[XLEN-1];
            end
          end
        end
        S_MUL: begin
          RESULT <= mul_word(opa_p0, opb_p0, fn_p0);
          BUSY   <= 1'b0;
          DONE   <= 1'b1;
          state  <= S_IDLE;
        end
        S_SPECIAL: begin
          RESULT <= special_word(opa_p0, fn_p0[1], opb_p0 == '0);
          BUSY   <= 1'b0;
          DONE   <= 1'b1;
          state  <= S_IDLE;
        end
        // stage p1: iterate, one quotient bit per cycle
        S_DIV: begin
          {rem_p1, quo_p1} <= div_step(rem_p1, quo_p1, dvs_p1);
          cnt_p1           <= cnt_p1 + 5'd1;
          if (cnt_p1 == 5'd31)
            state <= S_FIX;
        end
        // stage p2: sign fix-up and result
        S_FIX: begin
          RESULT <= fn_p0[1] ? cond_neg(rem_p1[XLEN-1:0], neg_r_p1)
                             : cond_neg(quo_p1, neg_q_p1);
          BUSY   <= 1'b0;
          DONE   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed and randomized ops against an arithmetic reference model.
module tb_mul_div_unit;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [31:0] RESULT;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (fn)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] fn, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!fn[2]) return 1;
    if (b == 0) return 1;
    if (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drives one op, scrambles inputs after acceptance, waits (bounded) for DONE.
  task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat,
                       output logic busy_acc, output logic busy_fin);
    @(negedge CLK);
    START = 1'b1; FUNCT3 = fn; DATA1 = a; DATA2 = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    busy_acc = BUSY;
    DATA1 = $urandom; DATA2 = $urandom; FUNCT3 = 3'($urandom);
    lat = 0;
    res = 'x;
    busy_fin = 1'bx;
    while (lat < 60) begin
      @(posedge CLK);
      #1;
      lat++;
      if (DONE) begin
        res = RESULT;
        busy_fin = BUSY;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd5; DATA2 = 32'd5;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (RESULT !== 32'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got result=%h busy=%b done=%b want 0/0/0", RESULT, BUSY, DONE);
    end
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] res, exp;
    int lat, exp_lat;
    logic ba, bf;
    exp = ref_model(fn, a, b);
    exp_lat = ref_latency(fn, a, b);
    do_op(fn, a, b, res, lat, ba, bf);
    total++;
    if (res !== exp || lat != exp_lat || ba !== 1'b1 || bf !== 1'b0) begin
      bad++;
      $display("FAIL %s: fn=%0d a=%h b=%h got res=%h lat=%0d busy=%b/%b want res=%h lat=%0d busy=1/0",
               name, fn, a, b, res, lat, ba, bf, exp, exp_lat);
    end
  endtask

  task automatic test_mul();
    check_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    total++;
    if (ref_model(3'd0, 32'd7, 32'hFFFF_FFFD) !== 32'hFFFF_FFEB || RESULT !== 32'hFFFF_FFEB) begin
      bad++;
      $display("FAIL mul_const: got %h want ffffffeb", RESULT);
    end
    check_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 24; i++)
      check_op("mul_rand", 3'(i % 4), $urandom, $urandom);
  endtask

  task automatic test_div();
    check_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    total++;
    if (RESULT !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_const: got %h want fffffffd", RESULT);
    end
    check_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    total++;
    if (RESULT !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL rem_const: got %h want ffffffff", RESULT);
    end
    check_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    check_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    check_op("div_min_2", 3'd4, 32'h8000_0000, 32'd2);
    check_op("rem_7_-2", 3'd6, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] b;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (b == 0) b = 32'd1;
      check_op("div_rand", 3'(4 + i % 4), $urandom, b);
    end
  endtask

  task automatic test_special();
    check_op("divu_zero", 3'd5, 32'd5, 32'd0);
    check_op("remu_zero", 3'd7, 32'd5, 32'd0);
    check_op("div_zero", 3'd4, 32'hFFFF_FFF9, 32'd0);
    check_op("rem_zero", 3'd6, 32'hFFFF_FFF9, 32'd0);
    check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("divu_min_m1", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'd5; DATA1 = 32'd100; DATA2 = 32'd7;
    @(posedge CLK);
    #1;
    START = 1'b0;
    lat = 0;
    res = 'x;
    while (lat < 60) begin
      @(negedge CLK);
      if (lat == 4) begin
        START = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd3; DATA2 = 32'd3;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK);
      #1;
      lat++;
      if (DONE) begin
        res = RESULT;
        break;
      end
    end
    START = 1'b0;
    total++;
    if (res !== 32'd14 || lat != 33) begin
      bad++;
      $display("FAIL busy_ignore: got res=%h lat=%0d want res=0000000e lat=33", res, lat);
    end
    check_op("b2b_mul", 3'd0, 32'd3, 32'd3);
    @(posedge CLK);
    #1;
    total++;
    if (DONE !== 1'b0 || RESULT !== 32'd9 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_hold: got done=%b res=%h busy=%b want 0/00000009/0", DONE, RESULT, BUSY);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'd4; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (BUSY !== 1'b0 || RESULT !== 32'h0) begin
      bad++;
      $display("FAIL abort_state: got busy=%b res=%h want 0/00000000", BUSY, RESULT);
    end
    @(negedge CLK);
    RESET = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (DONE) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got done_seen=%b want 0", seen);
    end
    check_op("divu_9_3", 3'd5, 32'd9, 32'd3);
  endtask

  initial begin
    RESET = 1'b0; START = 1'b0; FUNCT3 = 3'd0; DATA1 = 32'd0; DATA2 = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
